// File: rtl/lsu_data_memory_pkg.sv
// Shared types and access-decoding helpers for the LSU data memory and its
// forwarding-path load aligner.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        OK           = 2'b00,
        MISALIGNED   = 2'b01,
        OUT_OF_RANGE = 2'b10,
        ILLEGAL      = 2'b11
    } dmem_status_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // Highest-priority fault wins: ILLEGAL, then MISALIGNED, then OUT_OF_RANGE.
    function automatic dmem_status_e dmem_classify(input logic       i_write,
                                                   input logic [2:0] i_funct3,
                                                   input logic [1:0] i_addr,
                                                   input logic       i_oor);
        logic w_legal;
        logic w_mis;
        if (i_write)
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
        else
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                      (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
        w_mis = (((i_funct3 == F3_H) || (i_funct3 == F3_HU)) && i_addr[0]) ||
                ((i_funct3 == F3_W) && (i_addr != 2'b00));
        if (!w_legal)   return ILLEGAL;
        else if (w_mis) return MISALIGNED;
        else if (i_oor) return OUT_OF_RANGE;
        else            return OK;
    endfunction

    function automatic logic [3:0] dmem_byte_en(input logic [2:0] i_funct3,
                                                input logic [1:0] i_addr);
        case (i_funct3)
            F3_B:    return 4'b0001 << i_addr;
            F3_H:    return i_addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate sub-word store data so every enabled lane sees the right bytes.
    function automatic logic [31:0] dmem_store_lanes(input logic [2:0]  i_funct3,
                                                     input logic [31:0] i_wdata);
        case (i_funct3)
            F3_B:    return {4{i_wdata[7:0]}};
            F3_H:    return {2{i_wdata[15:0]}};
            default: return i_wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_memory_if.sv
// Request/response channel between the core memory stage and the data RAM.
interface lsu_data_memory_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_status
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_status
    );
endinterface

// File: rtl/lsu_data_memory_load_align.sv
// Selects the addressed byte/halfword of a loaded word and sign- or zero-extends
// it; shared with the core's store-to-load forwarding path.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr, 3'b000} +: 8];
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0000, w_half};
            default: o_data = i_word;
        endcase
    end
endmodule

// File: rtl/lsu_data_memory.sv
// Single-outstanding-request data RAM with RV32I byte/halfword/word semantics,
// programmable read latency and per-access error status.
module lsu_data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned WORDS             = 256,
    parameter int unsigned READ_LATENCY      = 1,
    parameter              MEM_INIT_FILENAME = ""
) (
    input logic               clk,
    input logic               reset_n,
    lsu_data_memory_if.slave  bus
);
    localparam int unsigned AW   = $clog2(WORDS);
    localparam logic [1:0]  LAST = 2'(READ_LATENCY - 1);

    logic [31:0]  r_mem [WORDS];
    dmem_state_e  r_state;
    dmem_state_e  w_state_nxt;
    logic [1:0]   r_cnt;
    logic [1:0]   w_cnt_nxt;
    logic [31:0]  r_rdata;
    dmem_status_e r_status;

    logic         w_accept;
    logic [AW-1:0] w_idx;
    logic         w_oor;
    dmem_status_e w_status;
    logic [3:0]   w_be;
    logic [31:0]  w_wlanes;
    logic [31:0]  w_word;
    logic [31:0]  w_load;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_idx    = bus.req_address[AW+1:2];
    assign w_oor    = |bus.req_address[31:AW+2];
    assign w_status = dmem_classify(bus.req_write, bus.req_funct3, bus.req_address[1:0], w_oor);
    assign w_be     = dmem_byte_en(bus.req_funct3, bus.req_address[1:0]);
    assign w_wlanes = dmem_store_lanes(bus.req_funct3, bus.req_wdata);
    assign w_word   = r_mem[w_idx];

    dmem_load_align u_align (
        .i_word   (w_word),
        .i_addr   (bus.req_address[1:0]),
        .i_funct3 (bus.req_funct3),
        .o_data   (w_load)
    );

    // Stores commit on the acceptance edge, so the next load always sees them.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_write && (w_status == OK)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= 2'd0;
            r_rdata  <= 32'h0;
            r_status <= OK;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_status <= w_status;
                r_rdata  <= ((w_status == OK) && !bus.req_write) ? w_load : 32'h0;
            end
        end
    end

    // Counter starts at 1 on acceptance so RESP is entered READ_LATENCY-1 edges later.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = 2'd0;
                if (w_accept) begin
                    if (READ_LATENCY > 1) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 2'd1;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            RESP: begin
                w_cnt_nxt = 2'd0;
                if (bus.rsp_ready) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_rdata  = r_rdata;
    assign bus.rsp_status = r_status;
endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed and random checks of two lsu_data_memory configurations against a
// byte-addressed reference model.
module tb_lsu_data_memory;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        v_valid = 1'b0;
    logic        v_write = 1'b0;
    logic [2:0]  v_f3 = 3'b000;
    logic [31:0] v_addr = 32'h0;
    logic [31:0] v_wdata = 32'h0;
    logic        v_rsp_ready = 1'b0;

    int nvec = 0;
    int nfail = 0;

    lsu_data_memory_if if1 ();
    lsu_data_memory_if if3 ();

    assign if1.req_valid   = v_valid && !sel;
    assign if1.req_write   = v_write;
    assign if1.req_funct3  = v_f3;
    assign if1.req_address = v_addr;
    assign if1.req_wdata   = v_wdata;
    assign if1.rsp_ready   = v_rsp_ready && !sel;
    assign if3.req_valid   = v_valid && sel;
    assign if3.req_write   = v_write;
    assign if3.req_funct3  = v_f3;
    assign if3.req_address = v_addr;
    assign if3.req_wdata   = v_wdata;
    assign if3.rsp_ready   = v_rsp_ready && sel;

    lsu_data_memory #(.WORDS(256), .READ_LATENCY(1), .MEM_INIT_FILENAME("")) u_dut1 (
        .clk(clk), .reset_n(rst_n), .bus(if1));
    lsu_data_memory #(.WORDS(64), .READ_LATENCY(3), .MEM_INIT_FILENAME("")) u_dut3 (
        .clk(clk), .reset_n(rst_n), .bus(if3));

    logic        o_rdy, o_vld;
    logic [31:0] o_rdata;
    logic [1:0]  o_status;
    assign o_rdy    = sel ? if3.req_ready  : if1.req_ready;
    assign o_vld    = sel ? if3.rsp_valid  : if1.rsp_valid;
    assign o_rdata  = sel ? if3.rsp_rdata  : if1.rsp_rdata;
    assign o_status = sel ? if3.rsp_status : if1.rsp_status;

    // Reference memory: index 0 models the 256-word part, index 1 the 64-word part.
    logic [7:0] mdl [2][1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit s, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic [1:0] st);
        int size;
        int limit;
        bit legal;
        logic [31:0] val;
        limit = s ? 256 : 1024;
        size  = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
        legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal)                       st = 2'd3;
        else if ((a % size) != 0)         st = 2'd1;
        else if (a >= 32'(limit))         st = 2'd2;
        else                              st = 2'd0;
        rd = 32'h0;
        if (st == 2'd0) begin
            if (wr) begin
                for (int i = 0; i < size; i++) mdl[s][a + i] = wd[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < size; i++) val = val | (32'(mdl[s][a + i]) << (8 * i));
                if ((f3 == 3'd0 || f3 == 3'd1) && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
                rd = val;
            end
        end
    endfunction

    task automatic do_req(input bit s, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] ord, output logic [1:0] ost);
        logic [31:0] erd;
        logic [1:0]  est;
        int k;
        int rl;
        rl = s ? 3 : 1;
        model(s, wr, f3, a, wd, erd, est);
        @(negedge clk);
        sel = s; v_write = wr; v_f3 = f3; v_addr = a; v_wdata = wd;
        chk("req_ready_idle", 32'(o_rdy), 32'd1);
        v_valid = 1'b1;
        @(posedge clk);
        #1 v_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!o_vld) chk("req_ready_busy", 32'(o_rdy), 32'd0);
        end while (!o_vld && k < 10);
        chk("latency", 32'(k), 32'(rl));
        ord = o_rdata;
        ost = o_status;
        chk("rdata", ord, erd);
        chk("status", 32'(ost), 32'(est));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(o_vld), 32'd1);
            chk("hold_rdata", o_rdata, ord);
            chk("hold_ready", 32'(o_rdy), 32'd0);
        end
        v_rsp_ready = 1'b1;
        @(posedge clk);
        #1 v_rsp_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", 32'(o_vld), 32'd0);
        chk("ready_back", 32'(o_rdy), 32'd1);
    endtask

    logic [31:0] rd;
    logic [1:0]  st;
    logic [2:0]  f3_tab [7];

    initial begin
        f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4;
        f3_tab[4] = 3'd5; f3_tab[5] = 3'd3; f3_tab[6] = 3'd6;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready1", 32'(if1.req_ready), 32'd1);
        chk("rst_valid1", 32'(if1.rsp_valid), 32'd0);
        chk("rst_rdata1", if1.rsp_rdata, 32'd0);
        chk("rst_status1", 32'(if1.rsp_status), 32'd0);
        chk("rst_ready3", 32'(if3.req_ready), 32'd1);
        chk("rst_valid3", 32'(if3.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < 256; w++) do_req(1'b0, 1'b1, 3'd2, 32'(4 * w), 32'h0, 0, rd, st);
        for (int w = 0; w < 64; w++)  do_req(1'b1, 1'b1, 3'd2, 32'(4 * w), 32'h0, 0, rd, st);

        do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, st);
        chk("sw_status", 32'(st), 32'd0);
        do_req(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, st);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);

        do_req(1'b0, 1'b1, 3'd0, 32'h21, 32'hAAAAAA80, 0, rd, st);
        do_req(1'b0, 1'b0, 3'd0, 32'h21, 32'h0, 0, rd, st);
        chk("lb_sext", rd, 32'hFFFFFF80);
        do_req(1'b0, 1'b0, 3'd4, 32'h21, 32'h0, 0, rd, st);
        chk("lbu_zext", rd, 32'h00000080);
        do_req(1'b0, 1'b0, 3'd2, 32'h20, 32'h0, 0, rd, st);
        chk("lw_after_sb", rd, 32'h00008000);

        do_req(1'b0, 1'b1, 3'd1, 32'h12, 32'h55551234, 0, rd, st);
        do_req(1'b0, 1'b0, 3'd1, 32'h12, 32'h0, 0, rd, st);
        chk("lh_1234", rd, 32'h00001234);
        do_req(1'b0, 1'b0, 3'd1, 32'h11, 32'h0, 0, rd, st);
        chk("lh_mis_status", 32'(st), 32'd1);
        chk("lh_mis_rdata", rd, 32'h0);
        do_req(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, st);
        chk("word_after_sh", rd, 32'h1234BEEF);
        do_req(1'b0, 1'b0, 3'd3, 32'h10, 32'h0, 0, rd, st);
        chk("f3_011_illegal", 32'(st), 32'd3);

        do_req(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 0, rd, st);
        chk("lw_oor", 32'(st), 32'd2);
        do_req(1'b1, 1'b1, 3'd2, 32'h100, 32'h12345678, 0, rd, st);
        chk("sw_oor", 32'(st), 32'd2);
        do_req(1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 0, rd, st);
        chk("no_alias_write", rd, 32'h0);
        do_req(1'b1, 1'b0, 3'd6, 32'h101, 32'h0, 0, rd, st);
        chk("illegal_priority", 32'(st), 32'd3);
        do_req(1'b1, 1'b1, 3'd2, 32'h8, 32'hCAFEF00D, 0, rd, st);
        do_req(1'b1, 1'b0, 3'd2, 32'h8, 32'h0, 5, rd, st);
        chk("rl3_hold_data", rd, 32'hCAFEF00D);

        // Reset while a latency-3 load is still waiting.
        @(negedge clk);
        sel = 1'b1; v_write = 1'b0; v_f3 = 3'd2; v_addr = 32'h8;
        v_valid = 1'b1;
        @(posedge clk);
        #1 v_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(if3.rsp_valid), 32'd0);
        chk("rst_mid_ready", 32'(if3.req_ready), 32'd1);
        chk("rst_mid_rdata", if3.rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b1, 1'b0, 3'd2, 32'h8, 32'h0, 0, rd, st);
        chk("store_survives_rst", rd, 32'hCAFEF00D);

        for (int n = 0; n < 300; n++) begin
            bit s;
            bit wr;
            logic [2:0] f3;
            logic [31:0] a;
            s  = n[0];
            wr = ($urandom_range(0, 2) == 0);
            f3 = ($urandom_range(0, 9) == 0) ? f3_tab[$urandom_range(5, 6)] : f3_tab[$urandom_range(0, 4)];
            a  = 32'($urandom_range(0, s ? 319 : 1279));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(($urandom_range(0, 1) == 0) ? 1 : 3);
            if ($urandom_range(0, 30) == 0) a = a | 32'h8000_0000;
            do_req(s, wr, f3, a, $urandom, $urandom_range(0, 2), rd, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
